// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder: byte stream -> FIPS 180-4 padded 512-bit blocks.
// `define SHA256_KROM_EN adds the K round-constant ROM (t_in -> k_out).
module sha256_block_feeder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_vbyte,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last
`ifdef SHA256_KROM_EN
  ,
  input  logic [5:0]   t_in,
  output logic [31:0]  k_out
`endif
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]        state;
  logic [6:0]        ptr;
  logic [LEN_W-1:0]  bitlen;
  logic [1:0]        extra;
  logic [0:63][7:0]  mem;
  logic [63:0]       len64;

  assign len64     = 64'(bitlen);
  assign blk_data  = mem;
  assign blk_valid = (state == S_OUT);
  assign in_ready  = (state == S_FILL);

  // Fill, pad and emit; extra remembers a pending length-only block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FILL;
      ptr      <= '0;
      bitlen   <= '0;
      extra    <= '0;
      blk_last <= 1'b0;
      mem      <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            if (in_vbyte) begin
              mem[ptr[5:0]] <= in_byte;
              ptr           <= ptr + 7'd1;
              bitlen        <= bitlen + LEN_W'(8);
            end
            if (in_last) begin
              state <= S_PAD;
            end else if (in_vbyte && ptr == 7'd63) begin
              state    <= S_OUT;
              blk_last <= 1'b0;
            end
          end
        end
        S_PAD: begin
          for (int i = 0; i < 64; i++) begin
            if (7'(i) == ptr)
              mem[i] <= 8'h80;
            else if (7'(i) > ptr)
              mem[i] <= 8'h00;
          end
          if (ptr < 7'd56) begin
            for (int j = 0; j < 8; j++)
              mem[56+j] <= len64[63-8*j -: 8];
            blk_last <= 1'b1;
          end else begin
            blk_last <= 1'b0;
            extra    <= (ptr == 7'd64) ? 2'd2 : 2'd1;
          end
          state <= S_OUT;
        end
        S_OUT: begin
          if (blk_ready) begin
            if (blk_last) begin
              ptr    <= '0;
              bitlen <= '0;
              extra  <= '0;
              state  <= S_FILL;
            end else if (extra != 2'd0) begin
              for (int i = 0; i < 56; i++)
                mem[i] <= 8'h00;
              if (extra == 2'd2)
                mem[0] <= 8'h80;
              for (int j = 0; j < 8; j++)
                mem[56+j] <= len64[63-8*j -: 8];
              blk_last <= 1'b1;
            end else begin
              ptr   <= '0;
              state <= S_FILL;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

`ifdef SHA256_KROM_EN
  localparam logic [0:63][31:0] KTAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k_out = KTAB[t_in];
`endif

endmodule
